// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared widths, FSM state type and restoring-divider step for the FP divider
package fp_div_pkg;

   localparam int MANT_W_DEF = 24;
   localparam int QW         = MANT_W_DEF + 2;
   localparam int CNT_W      = $clog2(QW);

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   // One restoring step: returns {quotient bit, remainder after conditional subtract}
   function automatic logic [MANT_W_DEF+1:0] cmp_sub(input logic [MANT_W_DEF:0] rem,
                                                     input logic [MANT_W_DEF-1:0] b);
      logic ge;
      ge = rem >= {1'b0, b};
      return {ge, ge ? rem - {1'b0, b} : rem};
   endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// fp_div_mant_iter: sequential radix-2 restoring mantissa divider with sticky bit and sideband tag
module fp_div_mant_iter
   import fp_div_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int TAG_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] a_mant,
   input  logic [MANT_W-1:0] b_mant,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W+1:0] q_mant,
   output logic              sticky,
   output logic              div_zero,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int QBITS = MANT_W + 2;
   localparam int CBITS = $clog2(QBITS);

   div_state_t        state_q, state_d;
   logic [MANT_W:0]   rem_q, rem_d;
   logic [MANT_W-1:0] b_q, b_d;
   logic [QBITS-1:0]  q_q, q_d;
   logic [CBITS-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              sticky_q, sticky_d;
   logic              dz_q, dz_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [MANT_W_DEF+1:0] step;
   logic [MANT_W:0]   rem_sub;

   // Next-state and datapath: capture in IDLE, one quotient bit per RUN cycle, hold in DONE
   always_comb begin
      step        = cmp_sub((MANT_W_DEF+1)'(rem_q), MANT_W_DEF'(b_q));
      rem_sub     = step[MANT_W:0];
      state_d     = state_q;
      rem_d       = rem_q;
      b_d         = b_q;
      q_d         = q_q;
      cnt_d       = cnt_q;
      tag_d       = tag_q;
      sticky_d    = sticky_q;
      dz_d        = dz_q;
      case (state_q)
         IDLE: if (in_valid && in_ready_q) begin
            tag_d    = in_tag;
            b_d      = b_mant;
            sticky_d = 1'b0;
            dz_d     = ~b_mant[MANT_W-1];
            q_d      = b_mant[MANT_W-1] ? '0 : '1;
            rem_d    = b_mant[MANT_W-1] ? {1'b0, a_mant} : '0;
            cnt_d    = b_mant[MANT_W-1] ? CBITS'(QBITS - 1) : '0;
            state_d  = b_mant[MANT_W-1] ? RUN : DONE;
         end
         RUN: begin
            q_d[cnt_q] = step[MANT_W_DEF+1];
            rem_d      = rem_sub << 1;
            if (cnt_q == '0) begin
               state_d  = DONE;
               sticky_d = |rem_sub;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: if (out_valid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d  = state_d == IDLE;
      out_valid_d = state_d == DONE;
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         b_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         sticky_q    <= 1'b0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         b_q         <= b_d;
         q_q         <= q_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         sticky_q    <= sticky_d;
         dz_q        <= dz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign q_mant    = q_q;
   assign sticky    = sticky_q;
   assign div_zero  = dz_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_fp_div_mant_iter.sv
// tb_fp_div_mant_iter: scoreboard bench for the iterative mantissa divider
module tb_fp_div_mant_iter;

   localparam int MW = 24;
   localparam int TW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [MW-1:0] a_mant = '0;
   logic [MW-1:0] b_mant = '0;
   logic [TW-1:0] in_tag = '0;
   logic          in_ready, out_valid, sticky, div_zero;
   logic [MW+1:0] q_mant;
   logic [TW-1:0] out_tag;

   typedef struct {
      logic [MW+1:0] q;
      logic          st;
      logic          dz;
      logic [TW-1:0] tag;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic prev_ov = 1'b0;

   fp_div_mant_iter #(.MANT_W(MW), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_mant(a_mant), .b_mant(b_mant), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .q_mant(q_mant),
      .sticky(sticky), .div_zero(div_zero), .out_tag(out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                  input logic [TW-1:0] t);
      exp_t        e;
      logic [63:0] n, qq;
      e.tag = t;
      if (!b[MW-1]) begin
         e.q = '1; e.st = 1'b0; e.dz = 1'b1; e.lat = 0;
      end else begin
         n    = {40'd0, a} << (MW + 1);
         qq   = n / {40'd0, b};
         e.q  = qq[MW+1:0];
         e.st = (n % {40'd0, b}) != 64'd0;
         e.dz = 1'b0;
         e.lat = MW + 2;
      end
      return e;
   endfunction

   task automatic send(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [TW-1:0] t);
      int w = 0;
      a_mant = a; b_mant = b; in_tag = t; in_valid = 1'b1;
      while (in_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 100) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      sb.push_back(model(a, b, t));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() > 0 && w < 200) begin
         @(posedge clk); #1; w++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Monitor: latency on out_valid rise, full result compare on handshake
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n) begin
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
            else chk("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("q_mant", 64'(q_mant), 64'(e.q));
            chk("sticky", 64'(sticky), 64'(e.st));
            chk("div_zero", 64'(div_zero), 64'(e.dz));
            chk("out_tag", 64'(out_tag), 64'(e.tag));
         end
      end
      prev_ov = out_valid && rst_n;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   t0, seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_q_mant", 64'(q_mant), 64'd0);
      chk("rst_flags", {62'd0, sticky, div_zero}, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(24'h866666, 24'hCCCCCC, 10'h001);
      drain();
      send(24'hCCCCCC, 24'h800000, 10'h155);
      drain();
      send(24'h800000, 24'h800000, 10'h002);
      drain();
      send(24'hFFFFFF, 24'h800000, 10'h003);
      drain();
      send(24'hABCDEF, 24'h000000, 10'h004);
      drain();

      t0 = acc_cyc;
      send(24'h9A0F31, 24'hF00001, 10'h005);
      t0 = acc_cyc;
      send(24'hC00000, 24'hFFFFFF, 10'h006);
      chk("throughput", 64'(acc_cyc - t0), 64'(MW + 4));
      drain();

      for (int i = 0; i < 6; i++) begin
         send(24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom), 10'($urandom));
         drain();
      end

      out_ready = 1'b0;
      send(24'h866666, 24'hCCCCCC, 10'h2AA);
      e = sb[0];
      seen = 0;
      while (!out_valid && seen < 100) begin
         @(posedge clk); #1; seen++;
      end
      chk("stall_valid", 64'(out_valid), 64'd1);
      a_mant = 24'h800000; b_mant = 24'h000000; in_tag = 10'h3FF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_hold_q", 64'(q_mant), 64'(e.q));
         chk("stall_hold_tag", {53'd0, out_tag, sticky}, {53'd0, e.tag, e.st});
         chk("stall_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      send(24'hCCCCCC, 24'h800000, 10'h0F0);
      drain();

      send(24'h866666, 24'hCCCCCC, 10'h011);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrun_no_result", 64'(seen), 64'd0);
      send(24'h866666, 24'hCCCCCC, 10'h012);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
